add_multicycle: RTL
===================

Name: add_multicycle

Overview:
- Parametrised multi-cycle adder/subtractor, the successor to the fixed 4-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, with a registered carry between chunks.
- Used in area-constrained datapaths (ALU slow path, address generation) where a full-width ripple chain in one cycle is too slow.
- Valid/ready handshakes on the input and output sides.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: s=a+b+cin; 1: s=a-b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow.
- zero  output  1  s == 0.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, s=0, cout=0, ovf=0, zero=0, chunk counter=0.
- Operand mapping: effective B = sub ? ~b : b; initial carry = sub ? 1 : cin.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid=1 at a rising edge:
  - capture a, effective B and initial carry;
  - clear the s register and counter;
  - go to RUN.
  - in_ready drops to 0 in the following cycle.
- RUN, per edge: compute chunk k = bits [k*CHUNK +: CHUNK] as A_k + B_k + carry.
  - Write the CHUNK sum bits into s at that position; register the chunk carry-out.
  - Increment k.
  - On the edge processing k = NCHUNK-1, go to DONE. Latch cout = final carry; ovf = carry into MSB XOR carry out of MSB; zero = (final s == 0).
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge (8 cycles for defaults; 1 cycle when CHUNK=WIDTH).
- Intermediate visibility: s, cout, ovf and zero are don't-care while out_valid=0. The bench checks them only when out_valid=1. The RTL updates s incrementally as described.
- DONE: out_valid=1; s, cout, ovf and zero held stable.
  - On out_ready=1 at an edge, go to IDLE; out_valid=0 next cycle.
  - Outputs keep their values until the next accept.
- Handshake rules:
  - in_ready=1 only in IDLE. in_valid outside IDLE is ignored; no queuing.
  - No back-to-back overlap. Throughput is one operation per NCHUNK+2 cycles with out_ready held high.
- Input stability: a, b, cin and sub are sampled only at the accepting edge; later changes have no effect.
- Reset mid-operation: asserting rst_n=0 in RUN or DONE aborts immediately and asynchronously to the reset values. The in-flight result is lost and no out_valid is produced.
- Arithmetic: modulo 2^WIDTH; no saturation. Unsigned overflow is reported via cout only.

Test Plan (WIDTH=32, CHUNK=4):
- add a=0x0000000F, b=0x00000001, cin=0 -> out_valid exactly 8 cycles after accept; s=0x00000010, cout=0, ovf=0, zero=0.
- add a=0xFFFFFFFF, b=0x00000001, cin=0 -> s=0x00000000, cout=1, ovf=0, zero=1. Add a=0x7FFFFFFF, b=0x00000001 -> s=0x80000000, ovf=1, cout=0. Add a=1, b=1, cin=1 -> s=0x00000003.
- sub a=5, b=7, cin=1 (ignored) -> s=0xFFFFFFFE, cout=0, ovf=0. Sub a=0x80000000, b=1 -> s=0x7FFFFFFF, cout=1, ovf=1. Sub a=b=0x12345678 -> s=0, zero=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> out_valid stays 1, outputs unchanged, in_ready=0, new operands never processed. Then out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset mid-RUN: drive rst_n=0 after 3 chunk cycles -> outputs immediately at reset values, in_ready=1 after release, no out_valid. A subsequent add 0x0000000A+0x00000005 returns s=0x0000000F in 8 cycles.
- Parameter sweep: CHUNK=32 (1-cycle latency) and CHUNK=1 (32-cycle latency) -> 1000 random a, b, cin, sub each match the reference model for s, cout, ovf and zero.

Source files
------------

// File: rtl/add_multicycle_if.sv
`default_nettype none
// ============================================================================
//  Module      : add_multicycle_if
//  Description : Valid/ready operand and result bundle for add_multicycle.
//                The master drives operands and accepts results. The slave
//                (the adder) consumes operands and presents results.
//  Revision    : 1.0  initial release
// ============================================================================
interface add_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface
`default_nettype wire

// File: rtl/add_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : add_multicycle
//  Description : Multi-cycle adder/subtractor. It processes CHUNK bits per
//                clock, LSB chunk first, with a registered carry between
//                chunks. Valid/ready handshake on both sides. Only one
//                operation is in flight at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module add_multicycle #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  add_multicycle_if.slave  bus
);

  localparam int c_NCHUNK = WIDTH / CHUNK;
  localparam int c_CW     = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
  localparam logic [WIDTH-1:0] c_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_CW-1:0]   r_k;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;        // already inverted for subtract
  logic              r_carry;
  logic [WIDTH-1:0]  r_s;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;
  logic              r_in_ready;
  logic              r_out_valid;

  logic [31:0]       w_pos;
  logic [CHUNK-1:0]  w_a_chunk;
  logic [CHUNK-1:0]  w_b_chunk;
  logic [CHUNK:0]    w_chunk_sum;
  logic [WIDTH-1:0]  w_s_next;
  logic              w_last;
  logic              w_msb_cin;
  logic              w_ovf;

  // Chunk datapath: select the current chunk by shifting, add it, and merge
  // it back into the partial result at the same bit position.
  always_comb begin
    w_pos       = 32'(r_k) * 32'(CHUNK);
    w_a_chunk   = CHUNK'(r_a >> w_pos);
    w_b_chunk   = CHUNK'(r_b >> w_pos);
    w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_s_next    = (r_s & ~(c_MASK << w_pos)) |
                  (WIDTH'(w_chunk_sum[CHUNK-1:0]) << w_pos);
    w_last      = (r_k == c_CW'(c_NCHUNK - 1));
    // The carry into the MSB is recovered from the MSB sum bit, so it does
    // not need a separate tap inside the chunk adder.
    w_msb_cin   = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s_next[WIDTH-1];
    w_ovf       = w_msb_cin ^ w_chunk_sum[CHUNK];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.sub ? ~bus.b : bus.b;
            r_carry    <= bus.sub ? 1'b1 : bus.cin;
            r_s        <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_s     <= w_s_next;
          r_carry <= w_chunk_sum[CHUNK];
          if (w_last) begin
            r_cout      <= w_chunk_sum[CHUNK];
            r_ovf       <= w_ovf;
            r_zero      <= (w_s_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_k <= r_k + c_CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.s         = r_s;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

endmodule
`default_nettype wire
